// File: rtl/uart_tx_fifo_if.sv
// Byte-write and line-status bundle between a producer and the buffered UART transmitter.
interface uart_tx_fifo_if;
  logic [7:0] i_data;
  logic       i_wr;
  logic       o_full;
  logic       o_empty;
  logic       o_busy;
  logic       o_tx;

  modport master (output i_data, i_wr, input o_full, o_empty, o_busy, o_tx);
  modport slave  (input i_data, i_wr, output o_full, o_empty, o_busy, o_tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding a start/data/stop serialiser.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_AW      = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_fifo_if.slave bus
);

  localparam int Depth = 1 << FIFO_AW;
  localparam int PtrW  = FIFO_AW + 1;
  localparam int CntW  = $clog2(DELAY_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q, count_q;
  logic              wrAcc, pop, bitDone, fifoEmpty;
  logic              txBit, busy;

  // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
  assign fifoEmpty = (count_q == '0);
  assign wrAcc     = bus.i_wr && (count_q < PtrW'(Depth));
  assign bitDone   = (cyc_q == CntW'(DELAY_FRAMES - 1));
  assign pop       = !fifoEmpty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bitDone));

  always_ff @(posedge i_clk) begin
    if (wrAcc) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wrAcc) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_q + PtrW'(wrAcc) - PtrW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The stop bit chains straight into the next start bit when a byte is waiting.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = pop ? mem_q[rptr_q[FIFO_AW-1:0]] : shift_q;
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (pop) begin
          state_d = START;
        end
      end
      START: begin
        if (bitDone) begin
          state_d = DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      DATA: begin
        if (bitDone) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      STOP: begin
        if (bitDone) begin
          cyc_d   = '0;
          state_d = pop ? START : IDLE;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txBit = 1'b1;
    busy  = 1'b1;
    unique case (state_q)
      IDLE:    busy  = 1'b0;
      START:   txBit = 1'b0;
      DATA:    txBit = shift_q[bit_q];
      default: txBit = 1'b1;
    endcase
  end

  assign bus.o_tx    = txBit;
  assign bus.o_busy  = busy;
  assign bus.o_empty = fifoEmpty;
  assign bus.o_full  = (count_q == PtrW'(Depth));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomised checks of the buffered UART transmitter against a line-decoding byte model.
module tb_uart_tx_fifo;

  localparam int D     = 217;
  localparam int Frame = 10 * D;

  logic        clk = 1'b0;
  logic        rst;
  int          checks   = 0;
  int          failures = 0;
  int          busyCnt  = 0;
  int unsigned cyc      = 0;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_AW(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  // Free-running cycle count and a running total of cycles spent busy.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_busy === 1'b1) busyCnt <= busyCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers each byte for one cycle, then scribbles i_data to show stored bytes are immune.
  task automatic applyStimulus(input logic [7:0] q[$], input int maxGap);
    foreach (q[i]) begin
      bus.i_data = q[i];
      bus.i_wr   = 1'b1;
      @(negedge clk);
      bus.i_wr   = 1'b0;
      bus.i_data = 8'hEE;
      repeat ($urandom_range(maxGap, 0)) @(negedge clk);
    end
  endtask

  // Decodes one 8N1 frame sample by sample, requiring every bit to hold exactly D cycles.
  task automatic recvFrame(input string tag, output logic [7:0] b, output int gap,
                           output int unsigned startCyc);
    logic [9:0] bits;
    bit glitch;
    glitch = 1'b0;
    gap = 0;
    while (bus.o_tx !== 1'b0 && gap < 3 * Frame) begin
      @(negedge clk);
      gap++;
    end
    checkOutput({tag, "_start"}, 32'(bus.o_tx), 32'd0);
    startCyc = cyc;
    for (int k = 0; k < 10; k++) begin
      bits[k] = bus.o_tx;
      for (int j = 0; j < D; j++) begin
        if (bus.o_tx !== bits[k]) glitch = 1'b1;
        @(negedge clk);
      end
    end
    b = bits[8:1];
    checkOutput({tag, "_stopbit"}, 32'(bits[9]), 32'd1);
    checkOutput({tag, "_bittiming"}, 32'(glitch), 32'd0);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  b;
    int          gap;
    int          b0;
    int unsigned tS, tFirst;
    bit          sawLow;

    rst = 1'b1;
    bus.i_wr = 1'b0;
    bus.i_data = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("reset_tx", 32'(bus.o_tx), 32'd1);
    checkOutput("reset_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset_empty", 32'(bus.o_empty), 32'd1);
    checkOutput("reset_full", 32'(bus.o_full), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte: latency, bit pattern and busy duration.
    b0 = busyCnt;
    bus.i_data = 8'h7F;
    bus.i_wr = 1'b1;
    @(negedge clk);
    bus.i_wr = 1'b0;
    bus.i_data = 8'h00;
    checkOutput("lat_empty_after_write", 32'(bus.o_empty), 32'd0);
    checkOutput("lat_tx_still_idle", 32'(bus.o_tx), 32'd1);
    checkOutput("lat_busy_still_low", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    checkOutput("lat_tx_low", 32'(bus.o_tx), 32'd0);
    checkOutput("lat_busy_high", 32'(bus.o_busy), 32'd1);
    checkOutput("lat_empty_after_pop", 32'(bus.o_empty), 32'd1);
    recvFrame("single", b, gap, tS);
    checkOutput("single_byte", 32'(b), 32'h7F);
    checkOutput("single_busy_cycles", 32'(busyCnt - b0), 32'(Frame));
    checkOutput("single_busy_falls", 32'(bus.o_busy), 32'd0);

    // Burst of three on consecutive cycles: contiguous frames.
    repeat (5) @(negedge clk);
    q = '{8'h55, 8'hA3, 8'h00};
    fork
      applyStimulus(q, 0);
    join_none
    tFirst = 0;
    for (int i = 0; i < 3; i++) begin
      recvFrame($sformatf("burst%0d", i), b, gap, tS);
      if (i == 0) tFirst = tS;
      else checkOutput($sformatf("burst%0d_gap", i), 32'(gap), 32'd0);
      checkOutput($sformatf("burst%0d_byte", i), 32'(b), 32'(q[i]));
    end
    checkOutput("burst_total_cycles", 32'(cyc - tFirst), 32'(3 * Frame));
    checkOutput("burst_idle_after", 32'(bus.o_busy), 32'd0);

    // Overflow: 20 writes, only the first 17 survive.
    repeat (5) @(negedge clk);
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'(i));
    fork
      applyStimulus(q, 0);
      begin
        repeat (16) @(negedge clk);
        checkOutput("ovf_full_after16", 32'(bus.o_full), 32'd0);
        @(negedge clk);
        checkOutput("ovf_full_after17", 32'(bus.o_full), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("ovf_full_held", 32'(bus.o_full), 32'd1);
      end
    join_none
    for (int i = 0; i < 17; i++) begin
      recvFrame($sformatf("ovf%0d", i), b, gap, tS);
      checkOutput($sformatf("ovf%0d_byte", i), 32'(b), 32'(i));
      if (i > 0) checkOutput($sformatf("ovf%0d_gap", i), 32'(gap), 32'd0);
      if (i == 14) checkOutput("ovf_not_yet_empty", 32'(bus.o_empty), 32'd0);
      if (i == 15) checkOutput("ovf_empty_after_last_pop", 32'(bus.o_empty), 32'd1);
    end
    sawLow = 1'b0;
    repeat (4 * D) begin
      if (bus.o_tx !== 1'b1) sawLow = 1'b1;
      @(negedge clk);
    end
    checkOutput("ovf_no_dropped_bytes_sent", 32'(sawLow), 32'd0);
    checkOutput("ovf_idle_after", 32'(bus.o_busy), 32'd0);

    // Reset during data bit 3 with two bytes still queued.
    q = '{8'hC3, 8'h5A, 8'h96};
    fork
      applyStimulus(q, 0);
    join_none
    gap = 0;
    while (bus.o_tx !== 1'b0 && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("mid_frame_started", 32'(bus.o_tx), 32'd0);
    repeat (4 * D + D / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_tx", 32'(bus.o_tx), 32'd1);
    checkOutput("mid_reset_empty", 32'(bus.o_empty), 32'd1);
    checkOutput("mid_reset_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("mid_reset_full", 32'(bus.o_full), 32'd0);
    rst = 1'b0;
    sawLow = 1'b0;
    repeat (12 * D) begin
      @(negedge clk);
      if (bus.o_tx !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("mid_reset_no_frames", 32'(sawLow), 32'd0);

    // Random bytes with random spacing; every byte must emerge in order, back to back.
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    fork
      applyStimulus(q, 3);
    join_none
    for (int i = 0; i < 6; i++) begin
      recvFrame($sformatf("rand%0d", i), b, gap, tS);
      checkOutput($sformatf("rand%0d_byte", i), 32'(b), 32'(q[i]));
      if (i > 0) checkOutput($sformatf("rand%0d_gap", i), 32'(gap), 32'd0);
    end
    checkOutput("rand_idle_after", 32'(bus.o_busy), 32'd0);
    checkOutput("rand_empty_after", 32'(bus.o_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
